uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver that generalises the existing fixed 8N1 receiver. It adds configurable data width, optional parity, 1 or 2 stop bits and an input synchroniser. It also adds false-start rejection, 3-sample majority voting, and error/break reporting. It sits between the board RX pin and the byte consumer, and presents each received frame as a single-cycle valid pulse with status flags.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in baud; BAUD_PERIOD = CLK_FREQ/BAUD_RATE (integer division), HALF = BAUD_PERIOD/2
DATA_BITS, 8, data bits per frame; legal range 5..9; LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_uart  input  1  asynchronous serial line, idle high
o_data  output  DATA_BITS  last received data word
o_valid  output  1  one-cycle pulse: frame complete, o_data and flags updated
o_parity_err  output  1  parity mismatch on last frame (0 when PARITY=0)
o_frame_err  output  1  any stop bit sampled low on last frame
o_break  output  1  last frame was a break (all data, parity and stop samples low)
o_busy  output  1  high from start-edge detection until return to IDLE

Behaviour:
- Reset: async assert when i_rst_n=0. All outputs go to 0, state goes to IDLE, counters clear. Synchroniser and sample shift register load 1, so no false edge occurs on release. Reset mid-frame abandons the frame with no o_valid.
- Input path: 2-FF synchroniser feeds a 3-bit shift register s[2:0] of synchronised samples. Bit value = majority(s[2],s[1],s[0]).
- Baud counter: width $clog2(BAUD_PERIOD+1). It reloads on every state transition, and the sample point is the counter reaching terminal count.
- IDLE: o_busy=0. A falling edge on the synchronised line (previous 1, current 0) loads the counter for HALF cycles and enters START. A line held low does not retrigger.
- START: at HALF cycles, majority is evaluated. If 1, the start is false: return to IDLE with no output. If 0, reload BAUD_PERIOD, clear bit index, enter DATA.
- DATA: sample every BAUD_PERIOD cycles into shift register position bit index (LSB first). After DATA_BITS samples, go to PARITY if PARITY!=0, else STOP.
- PARITY: sample one bit after BAUD_PERIOD.
  - Odd: error if XOR(data,parity)=0.
  - Even: error if XOR(data,parity)=1.
- STOP: sample STOP_BITS bits at BAUD_PERIOD intervals. Any 0 sets the frame error.
- Frame completion: after the last stop sample, return to IDLE immediately, so a start edge within the remaining half stop bit is accepted. On the next cycle:
  - o_valid=1 for exactly one cycle.
  - o_data is updated, together with o_parity_err, o_frame_err and o_break.
  - All four hold until the next o_valid.
- Errors: data is still delivered on frame or parity error. o_break implies o_frame_err=1.
- Break: a continuous low line produces exactly one o_valid, with o_break=1 and o_data=0. The next frame requires the line to return high, then fall.
- Latency: for edge detected at cycle E:
  - Start check at E+HALF.
  - Data bit n sampled at E+HALF+(n+1)·BAUD_PERIOD.
  - o_valid one cycle after the final stop sample.
- Glitch tolerance: a single-clock glitch at any sample point is rejected by the majority vote.

Test Plan:
- Default params, 8N1 frame 0xA5 at 217 clk/bit -> one o_valid pulse, o_data=0xA5, all flags 0, o_busy low after pulse.
- PARITY=2, byte 0x37 sent with parity bit 0 (correct is 1) -> o_valid, o_data=0x37, o_parity_err=1, o_frame_err=0; resend with parity 1 -> o_parity_err=0.
- Line low for 50 clocks then high -> no o_valid, o_busy high for ~108 clocks then 0; following frame 0x3C received correctly.
- 0x55 with stop bit 0 -> o_frame_err=1, o_data=0x55. Then line low for 12 bit-times -> single o_valid with o_break=1, o_data=0x00. Line high, then frame 0xC3 -> o_data=0xC3, flags 0.
- Reset asserted during data bit 4 of 0xFF -> outputs 0 immediately, no o_valid. After release, frame 0x81 -> o_data=0x81.
- DATA_BITS=7, PARITY=1, STOP_BITS=2: back-to-back frames 0x5A, 0x25 with 1-clock inverted glitches at each mid-bit -> two o_valid pulses, o_data=0x5A then 0x25, o_parity_err=0, o_frame_err=0.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote, optional parity,
// one or two stop bits, false-start rejection, frame-error and break reporting.
module uart_rx_param #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uart,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);
  localparam int BAUD_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int HALF        = BAUD_PERIOD / 2;
  localparam int CNT_W       = $clog2(BAUD_PERIOD + 1);
  localparam logic [CNT_W-1:0] BAUD_M1   = CNT_W'(BAUD_PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [3:0]       LAST_IDX  = 4'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic majority3(input logic [2:0] s);
    return (s[2] & s[1]) | (s[2] & s[0]) | (s[1] & s[0]);
  endfunction

  function automatic logic parity_error(input logic [DATA_BITS-1:0] data, input logic pbit);
    logic odd_ones;
    odd_ones = ^{data, pbit};
    case (PARITY)
      32'sd1:  return ~odd_ones;
      32'sd2:  return odd_ones;
      default: return 1'b0;
    endcase
  endfunction

  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]           samp_q, samp_d;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d, low_q, low_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 brk_q, brk_d, busy_q, busy_d;
  logic                 tick_s, bit_s, fall_s;

  assign tick_s = (cnt_q == CNT_ZERO);
  assign bit_s  = majority3(samp_q);
  assign fall_s = samp_q[1] & ~samp_q[0];

  // Next-state, sampling and frame-result logic.
  always_comb begin
    sync1_d    = i_uart;
    sync2_d    = sync1_q;
    samp_d     = {samp_q[1:0], sync2_q};
    state_d    = state_q;
    cnt_d      = tick_s ? cnt_q : cnt_q - CNT_ONE;
    idx_d      = idx_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    low_d      = low_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          state_d = S_START;
          cnt_d   = HALF_M1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_s) begin
          // A high majority at mid-start means the edge was noise.
          if (bit_s) begin
            state_d = S_IDLE;
            cnt_d   = HALF_M1;
          end else begin
            state_d    = S_DATA;
            cnt_d      = BAUD_M1;
            idx_d      = 4'd0;
            low_d      = 1'b1;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
          low_d   = low_q & ~bit_s;
          cnt_d   = BAUD_M1;
          if (idx_q == LAST_IDX) begin
            stop_d  = 1'b0;
            state_d = (PARITY != 32'sd0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (tick_s) begin
          perr_acc_d = parity_error(shift_q, bit_s);
          low_d      = low_q & ~bit_s;
          cnt_d      = BAUD_M1;
          stop_d     = 1'b0;
          state_d    = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (tick_s) begin
          ferr_acc_d = ferr_acc_q | ~bit_s;
          low_d      = low_q & ~bit_s;
          cnt_d      = BAUD_M1;
          // Leave for IDLE right at the last stop sample so an early next start is caught.
          if (stop_q == LAST_STOP) begin
            state_d = S_IDLE;
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_acc_q;
            ferr_d  = ferr_acc_d;
            brk_d   = low_d;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; line-side flops reset high so release gives no edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      samp_q     <= 3'b111;
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      idx_q      <= 4'd0;
      stop_q     <= 1'b0;
      shift_q    <= {DATA_BITS{1'b0}};
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      low_q      <= 1'b0;
      data_q     <= {DATA_BITS{1'b0}};
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      samp_q     <= samp_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      low_q      <= low_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = brk_q;
  assign o_busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7O2) driven by directed frames,
// checked every cycle against a frame-level model plus literal expectations.
module tb_uart_rx_param;
  localparam int P = 217;
  localparam int H = 108;

  typedef struct {
    int         id;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         nsamp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line [3] = '{default: 1'b1};
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic [2:0] valid_o, perr_o, ferr_o, brk_o, busy_o;
  logic [8:0] obs_data [3];

  assign obs_data[0] = {1'b0, data_a};
  assign obs_data[1] = {1'b0, data_b};
  assign obs_data[2] = {2'b00, data_c};

  uart_rx_param u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart(line[0]), .o_data(data_a), .o_valid(valid_o[0]),
    .o_parity_err(perr_o[0]), .o_frame_err(ferr_o[0]), .o_break(brk_o[0]), .o_busy(busy_o[0]));
  uart_rx_param #(.PARITY(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart(line[1]), .o_data(data_b), .o_valid(valid_o[1]),
    .o_parity_err(perr_o[1]), .o_frame_err(ferr_o[1]), .o_break(brk_o[1]), .o_busy(busy_o[1]));
  uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart(line[2]), .o_data(data_c), .o_valid(valid_o[2]),
    .o_parity_err(perr_o[2]), .o_frame_err(ferr_o[2]), .o_break(brk_o[2]), .o_busy(busy_o[2]));

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  logic [8:0] held_data [3];
  logic [2:0] held_perr = 3'b000, held_ferr = 3'b000, held_brk = 3'b000;
  logic [2:0] prev_busy = 3'b000;
  int         busy_t [3];
  int         busy_cnt [3];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Frame-level expectation straight from the frame format rules.
  function automatic exp_t model(input int id, input int nbits, input logic [8:0] data,
                                 input int pmode, input logic pbit, input int nstop,
                                 input logic [1:0] stops);
    exp_t       e;
    int         ones;
    logic [8:0] dm;
    logic       any_stop_high;
    dm = 9'd0;
    for (int i = 0; i < nbits; i++) dm[i] = data[i];
    ones = $countones(dm) + ((pmode != 0) ? int'(pbit) : 0);
    e.id    = id;
    e.data  = dm;
    e.perr  = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
    e.ferr  = 1'b0;
    any_stop_high = 1'b0;
    for (int i = 0; i < nstop; i++) begin
      if (!stops[i]) e.ferr = 1'b1;
      else any_stop_high = 1'b1;
    end
    e.brk   = (dm == 9'd0) && !((pmode != 0) && pbit) && !any_stop_high;
    e.nsamp = nbits + ((pmode != 0) ? 1 : 0) + nstop;
    return e;
  endfunction

  task automatic drive(input int id, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      line[id] = v;
    end
  endtask

  // abort_at >= 0 stops driving after that many cycles and expects no frame.
  task automatic send_frame(input int id, input int nbits, input logic [8:0] data, input int pmode,
                            input logic pbit, input int nstop, input logic [1:0] stops,
                            input bit glitch, input int abort_at);
    logic slots [16];
    int   ns;
    int   c;
    ns = 0;
    slots[ns] = 1'b0; ns++;
    for (int i = 0; i < nbits; i++) begin slots[ns] = data[i]; ns++; end
    if (pmode != 0) begin slots[ns] = pbit; ns++; end
    for (int i = 0; i < nstop; i++) begin slots[ns] = stops[i]; ns++; end
    if (abort_at < 0) exp_q.push_back(model(id, nbits, data, pmode, pbit, nstop, stops));
    c = 0;
    for (int s = 0; s < ns; s++) begin
      for (int k = 0; k < P; k++) begin
        if (abort_at >= 0 && c == abort_at) return;
        @(negedge clk);
        line[id] = (glitch && k == H - 1) ? ~slots[s] : slots[s];
        c++;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Per-cycle compare of every DUT against the model and the held result.
  initial begin
    exp_t e;
    int   want_v;
    for (int d = 0; d < 3; d++) begin
      held_data[d] = 9'd0;
      busy_t[d]    = 0;
      busy_cnt[d]  = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        if (busy_o[d] && !prev_busy[d]) busy_t[d] = cyc;
        if (busy_o[d]) busy_cnt[d]++;
        if (!rst_n) begin
          held_data[d] = 9'd0;
          held_perr[d] = 1'b0;
          held_ferr[d] = 1'b0;
          held_brk[d]  = 1'b0;
        end
        if (valid_o[d]) begin
          want_v = (exp_q.size() != 0 && exp_q[0].id == d) ? 1 : 0;
          chk("valid_expected", 32'(valid_o[d]), 32'(want_v));
          if (want_v == 1) begin
            e = exp_q.pop_front();
            chk("frame_data", 32'(obs_data[d]), 32'(e.data));
            chk("frame_perr", 32'(perr_o[d]), 32'(e.perr));
            chk("frame_ferr", 32'(ferr_o[d]), 32'(e.ferr));
            chk("frame_break", 32'(brk_o[d]), 32'(e.brk));
            chk("frame_latency", 32'(cyc - busy_t[d]), 32'(H + e.nsamp * P));
            held_data[d] = e.data;
            held_perr[d] = e.perr;
            held_ferr[d] = e.ferr;
            held_brk[d]  = e.brk;
          end
        end else begin
          chk("outputs_hold", 32'({obs_data[d], perr_o[d], ferr_o[d], brk_o[d]}),
              32'({held_data[d], held_perr[d], held_ferr[d], held_brk[d]}));
        end
      end
      prev_busy = busy_o;
    end
  end

  initial begin
    exp_t e;
    int   b0;
    repeat (3) @(negedge clk);
    chk("reset_a", 32'({obs_data[0], valid_o[0], perr_o[0], ferr_o[0], brk_o[0], busy_o[0]}), 32'd0);
    chk("reset_c", 32'({obs_data[2], valid_o[2], perr_o[2], ferr_o[2], brk_o[2], busy_o[2]}), 32'd0);
    rst_n = 1'b1;
    drive(0, 1'b1, 2 * P);

    e = model(1, 8, 9'h037, 2, 1'b0, 1, 2'b01);
    chk("model_perr_37_bad", 32'(e.perr), 32'd1);
    e = model(2, 7, 9'h05A, 1, 1'b1, 2, 2'b11);
    chk("model_perr_5a_odd", 32'(e.perr), 32'd0);
    e = model(0, 8, 9'h000, 0, 1'b0, 1, 2'b00);
    chk("model_break", 32'({e.brk, e.ferr, e.data}), 32'({1'b1, 1'b1, 9'h000}));

    // 8N1 basic frame.
    send_frame(0, 8, 9'h0A5, 0, 1'b0, 1, 2'b11, 1'b0, -1);
    drain();
    @(negedge clk);
    chk("t1_data", 32'(data_a), 32'h0A5);
    chk("t1_flags", 32'({perr_o[0], ferr_o[0], brk_o[0]}), 32'd0);
    chk("t1_busy", 32'(busy_o[0]), 32'd0);

    // Even parity, wrong then right parity bit.
    send_frame(1, 8, 9'h037, 2, 1'b0, 1, 2'b11, 1'b0, -1);
    drain();
    chk("t2_bad_perr", 32'({data_b, perr_o[1], ferr_o[1]}), 32'({8'h37, 1'b1, 1'b0}));
    drive(1, 1'b1, P);
    send_frame(1, 8, 9'h037, 2, 1'b1, 1, 2'b11, 1'b0, -1);
    drain();
    chk("t2_good_perr", 32'({data_b, perr_o[1], ferr_o[1]}), 32'({8'h37, 1'b0, 1'b0}));

    // False start: 50-cycle low pulse.
    b0 = busy_cnt[0];
    drive(0, 1'b0, 50);
    drive(0, 1'b1, 300);
    chk("t3_busy_cycles", 32'(busy_cnt[0] - b0), 32'd108);
    send_frame(0, 8, 9'h03C, 0, 1'b0, 1, 2'b11, 1'b0, -1);
    drain();
    chk("t3_data", 32'(data_a), 32'h03C);

    // Framing error, then break, then recovery.
    send_frame(0, 8, 9'h055, 0, 1'b0, 1, 2'b00, 1'b0, -1);
    drive(0, 1'b1, 2 * P);
    drain();
    chk("t4_ferr", 32'({data_a, ferr_o[0], brk_o[0]}), 32'({8'h55, 1'b1, 1'b0}));
    exp_q.push_back(model(0, 8, 9'h000, 0, 1'b0, 1, 2'b00));
    drive(0, 1'b0, 12 * P);
    drive(0, 1'b1, 2 * P);
    drain();
    chk("t4_break", 32'({data_a, ferr_o[0], brk_o[0]}), 32'({8'h00, 1'b1, 1'b1}));
    send_frame(0, 8, 9'h0C3, 0, 1'b0, 1, 2'b11, 1'b0, -1);
    drain();
    chk("t4_recover", 32'({data_a, perr_o[0], ferr_o[0], brk_o[0]}), 32'({8'hC3, 3'b000}));

    // Reset during data bit 4.
    drive(0, 1'b1, P);
    send_frame(0, 8, 9'h0FF, 0, 1'b0, 1, 2'b11, 1'b0, 5 * P + 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs",
        32'({data_a, valid_o[0], perr_o[0], ferr_o[0], brk_o[0], busy_o[0]}), 32'd0);
    drive(0, 1'b1, 5);
    rst_n = 1'b1;
    drive(0, 1'b1, 2 * P);
    send_frame(0, 8, 9'h081, 0, 1'b0, 1, 2'b11, 1'b0, -1);
    drain();
    chk("t5_data", 32'(data_a), 32'h081);

    // 7O2 back-to-back frames with a one-cycle glitch near each mid-bit.
    send_frame(2, 7, 9'h05A, 1, 1'b1, 2, 2'b11, 1'b1, -1);
    send_frame(2, 7, 9'h025, 1, 1'b0, 2, 2'b11, 1'b1, -1);
    drain();
    chk("t6_last", 32'({data_c, perr_o[2], ferr_o[2]}), 32'({7'h25, 1'b0, 1'b0}));

    drive(0, 1'b1, P);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
